pipeline_hazard_controller: RTL and testbench

Central sequencer for the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC. It produces per-stage enable and flush controls, and resolves three conditions:
- load-use hazards,
- taken-branch flushes,
- multi-cycle data-memory waits.
It also implements a halt/drain handshake that empties the pipeline before acknowledging a halt. It sits beside the datapath; every pipeline register takes its enable/flush from this block.

---
 rtl/pipeline_hazard_controller_pkg.sv | 15 +
 rtl/pipeline_hazard_controller_if.sv | 57 +++++
 rtl/pipeline_hazard_controller_hazard_detect_unit.sv | 20 ++
 rtl/pipeline_hazard_controller.sv | 204 ++++++++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// ARM register-index width and the PC register index.
package pipeline_hazard_controller_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_RUN      = 2'd0;
    localparam state_t ST_MEM_WAIT = 2'd1;
    localparam state_t ST_DRAIN    = 2'd2;
    localparam state_t ST_HALTED   = 2'd3;

    localparam int ARM_REG_W = 4;
    localparam logic [ARM_REG_W-1:0] PC_REG = 4'd15;

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Datapath <-> hazard controller bundle. The datapath side (master) drives the
// hazard inputs and consumes the per-stage enables/flushes; the controller is
// the slave. The perf counter outputs exist only with HAZARD_PERF_COUNTERS_EN.
interface pipeline_hazard_controller_if
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int REG_ADDR_W = ARM_REG_W,
    parameter int CNT_W      = 16
) ();
    logic [REG_ADDR_W-1:0] id_rn;
    logic [REG_ADDR_W-1:0] id_rm;
    logic                  id_rn_used;
    logic                  id_rm_used;
    logic                  ex_load;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  branch_taken;
    logic                  mem_req;
    logic                  mem_ready;
    logic                  halt_req;

    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
    logic mem_wb_en;
    logic mem_wb_flush;
    logic halt_ack;
    logic mem_timeout_err;
`ifdef HAZARD_PERF_COUNTERS_EN
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;
    logic [CNT_W-1:0] wait_cycles;
`endif

    modport master (
        output id_rn, id_rm, id_rn_used, id_rm_used, ex_load, ex_rd,
        output branch_taken, mem_req, mem_ready, halt_req,
        input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
        input  ex_mem_en, mem_wb_en, mem_wb_flush, halt_ack, mem_timeout_err
`ifdef HAZARD_PERF_COUNTERS_EN
        , input stall_cycles, flush_events, wait_cycles
`endif
    );

    modport slave (
        input  id_rn, id_rm, id_rn_used, id_rm_used, ex_load, ex_rd,
        input  branch_taken, mem_req, mem_ready, halt_req,
        output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
        output ex_mem_en, mem_wb_en, mem_wb_flush, halt_ack, mem_timeout_err
`ifdef HAZARD_PERF_COUNTERS_EN
        , output stall_cycles, flush_events, wait_cycles
`endif
    );

endinterface

// File: rtl/pipeline_hazard_controller_hazard_detect_unit.sv
// Load-use detector: flags when the load in EX writes a register that the
// instruction in ID actually reads. Purely combinational.
module hazard_detect_unit
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int REG_ADDR_W = ARM_REG_W
) (
    input  logic                  ex_load,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [REG_ADDR_W-1:0] id_rn,
    input  logic [REG_ADDR_W-1:0] id_rm,
    input  logic                  id_rn_used,
    input  logic                  id_rm_used,
    output logic                  load_use
);

    assign load_use = ex_load && ((id_rn_used && (id_rn == ex_rd)) ||
                                  (id_rm_used && (id_rm == ex_rd)));

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: per-stage enable/flush generation for load-use
// stalls, taken-branch flushes, data-memory waits and a halt/drain handshake.
// Optional build macro: HAZARD_PERF_COUNTERS_EN adds saturating stall/flush/wait
// event counters on the interface.
//
// state     | meaning
// ----------+------------------------------------------------------------
// RUN       | normal issue; hazards resolved by priority
// MEM_WAIT  | data memory stalled; returns to ret_state when the access ends
// DRAIN     | fetch stopped, pipeline emptying toward halt
// HALTED    | pipeline empty, halt_ack high until halt_req drops
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int REG_ADDR_W   = ARM_REG_W,
    parameter int DRAIN_CYCLES = 4,
    parameter int MEM_TIMEOUT  = 16,
    parameter int CNT_W        = 16
) (
    input  logic clk,
    input  logic reset,
    pipeline_hazard_controller_if.slave hz
);

    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [WAIT_W-1:0]  WAIT_MAX   = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(MEM_TIMEOUT - 1);

    state_t state, state_nxt;
    state_t ret_state, ret_nxt;
    logic [DRAIN_W-1:0] drain_cnt, drain_nxt;
    logic [WAIT_W-1:0]  wait_cnt;
    logic timeout_err;
    logic load_use;
    logic active;
    logic mem_wait;
    logic draining;

    hazard_detect_unit #(.REG_ADDR_W(REG_ADDR_W)) u_hdu (
        .ex_load    (hz.ex_load),
        .ex_rd      (hz.ex_rd),
        .id_rn      (hz.id_rn),
        .id_rm      (hz.id_rm),
        .id_rn_used (hz.id_rn_used),
        .id_rm_used (hz.id_rm_used),
        .load_use   (load_use)
    );

    assign active   = (state != ST_HALTED);
    assign mem_wait = active && hz.mem_req && !hz.mem_ready;
    // A wait that interrupted a drain keeps fetch stopped until the drain resumes.
    assign draining = (state == ST_DRAIN) ||
                      ((state == ST_MEM_WAIT) && (ret_state == ST_DRAIN));

    // Next-state, return-state and drain-count selection
    always_comb begin
        state_nxt = state;
        ret_nxt   = ret_state;
        drain_nxt = drain_cnt;
        case (state)
            ST_RUN: begin
                if (mem_wait) begin
                    state_nxt = ST_MEM_WAIT;
                    ret_nxt   = ST_RUN;
                end else if (hz.halt_req) begin
                    state_nxt = ST_DRAIN;
                    drain_nxt = '0;
                end
            end
            ST_MEM_WAIT: begin
                if (!mem_wait) begin
                    // The completing cycle advances the pipeline, so it counts as a drain step.
                    if (ret_state != ST_DRAIN) begin
                        state_nxt = ST_RUN;
                    end else if (!hz.halt_req) begin
                        state_nxt = ST_RUN;
                    end else if (drain_cnt == DRAIN_LAST) begin
                        state_nxt = ST_HALTED;
                    end else begin
                        state_nxt = ST_DRAIN;
                        drain_nxt = drain_cnt + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (mem_wait) begin
                    state_nxt = ST_MEM_WAIT;
                    ret_nxt   = ST_DRAIN;
                end else if (!hz.halt_req) begin
                    state_nxt = ST_RUN;
                end else if (drain_cnt == DRAIN_LAST) begin
                    state_nxt = ST_HALTED;
                end else begin
                    drain_nxt = drain_cnt + 1'b1;
                end
            end
            ST_HALTED: begin
                if (!hz.halt_req) state_nxt = ST_RUN;
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    // FSM, return-state and drain counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_RUN;
            ret_state <= ST_RUN;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            ret_state <= ret_nxt;
            drain_cnt <= drain_nxt;
        end
    end

    // Memory wait counter and sticky timeout flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else if (mem_wait) begin
            if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt >= WAIT_LAST) timeout_err <= 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    assign hz.mem_timeout_err = timeout_err;

    // Per-stage controls: memory wait > taken branch > load-use, drain/halt overlays
    always_comb begin
        hz.pc_en        = 1'b1;
        hz.if_id_en     = 1'b1;
        hz.if_id_flush  = 1'b0;
        hz.id_ex_en     = 1'b1;
        hz.id_ex_flush  = 1'b0;
        hz.ex_mem_en    = 1'b1;
        hz.mem_wb_en    = 1'b1;
        hz.mem_wb_flush = 1'b0;
        hz.halt_ack     = 1'b0;
        if (!reset) begin
            hz.pc_en     = 1'b0;
            hz.if_id_en  = 1'b0;
            hz.id_ex_en  = 1'b0;
            hz.ex_mem_en = 1'b0;
            hz.mem_wb_en = 1'b0;
        end else if (state == ST_HALTED) begin
            hz.pc_en       = 1'b0;
            hz.if_id_flush = 1'b1;
            hz.halt_ack    = 1'b1;
        end else begin
            if (mem_wait) begin
                hz.pc_en        = 1'b0;
                hz.if_id_en     = 1'b0;
                hz.id_ex_en     = 1'b0;
                hz.ex_mem_en    = 1'b0;
                hz.mem_wb_flush = 1'b1;
            end else if (hz.branch_taken) begin
                hz.pc_en       = 1'b1;
                hz.if_id_flush = 1'b1;
                hz.id_ex_flush = 1'b1;
            end else if (load_use) begin
                hz.pc_en       = 1'b0;
                hz.if_id_en    = 1'b0;
                hz.id_ex_flush = 1'b1;
            end
            if (draining) begin
                // Only a resolved branch target may still load the PC while draining.
                hz.pc_en       = hz.branch_taken && !mem_wait;
                hz.if_id_flush = 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_COUNTERS_EN
    logic [CNT_W-1:0] stall_q, flush_q, wait_q;
    logic stall_ev, flush_ev;

    assign stall_ev = active && !mem_wait && !hz.branch_taken && load_use;
    assign flush_ev = active && !mem_wait && hz.branch_taken;

    // Saturating event counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
            flush_q <= '0;
            wait_q  <= '0;
        end else begin
            if (stall_ev && (stall_q != '1)) stall_q <= stall_q + 1'b1;
            if (flush_ev && (flush_q != '1)) flush_q <= flush_q + 1'b1;
            if (mem_wait && (wait_q  != '1)) wait_q  <= wait_q + 1'b1;
        end
    end

    assign hz.stall_cycles = stall_q;
    assign hz.flush_events = flush_q;
    assign hz.wait_cycles  = wait_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed self-checking bench for pipeline_hazard_controller.
module tb_pipeline_hazard_controller;
    import pipeline_hazard_controller_pkg::*;

    // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en, mem_wb_flush, halt_ack}
    localparam logic [8:0] C_RST    = 9'b000000000;
    localparam logic [8:0] C_DEF    = 9'b110101100;
    localparam logic [8:0] C_LU     = 9'b000111100;
    localparam logic [8:0] C_BR     = 9'b111111100;
    localparam logic [8:0] C_WAIT   = 9'b000000110;
    localparam logic [8:0] C_DRAIN  = 9'b011101100;
    localparam logic [8:0] C_DRWAIT = 9'b001000110;
    localparam logic [8:0] C_HALT   = 9'b011101101;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    pipeline_hazard_controller_if #(.REG_ADDR_W(ARM_REG_W), .CNT_W(16)) hz ();

    pipeline_hazard_controller #(
        .REG_ADDR_W   (ARM_REG_W),
        .DRAIN_CYCLES (4),
        .MEM_TIMEOUT  (16),
        .CNT_W        (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    logic [8:0] ctl;
    assign ctl = {hz.pc_en, hz.if_id_en, hz.if_id_flush, hz.id_ex_en, hz.id_ex_flush,
                  hz.ex_mem_en, hz.mem_wb_en, hz.mem_wb_flush, hz.halt_ack};

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hz.id_rn        = 4'd0;
        hz.id_rm        = 4'd0;
        hz.id_rn_used   = 1'b0;
        hz.id_rm_used   = 1'b0;
        hz.ex_load      = 1'b0;
        hz.ex_rd        = 4'd0;
        hz.branch_taken = 1'b0;
        hz.mem_req      = 1'b0;
        hz.mem_ready    = 1'b0;
        hz.halt_req     = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        idle();
        #2;
        chk_eq("rst_ctl", 32'(ctl), 32'(C_RST));
        chk_eq("rst_err", 32'(hz.mem_timeout_err), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #1 chk_eq("def_run", 32'(ctl), 32'(C_DEF));
        tick();

        // load-use on rn, then the load moves on
        hz.ex_load = 1'b1; hz.ex_rd = 4'd3; hz.id_rn = 4'd3; hz.id_rn_used = 1'b1;
        #1 chk_eq("lu_rn", 32'(ctl), 32'(C_LU));
        tick();
        hz.ex_load = 1'b0;
        #1 chk_eq("lu_no_load", 32'(ctl), 32'(C_DEF));
        tick();
        hz.ex_load = 1'b1; hz.ex_rd = 4'd11;
        #1 chk_eq("lu_full_width", 32'(ctl), 32'(C_DEF));
        hz.ex_rd = PC_REG; hz.id_rm = PC_REG; hz.id_rn_used = 1'b0; hz.id_rm_used = 1'b0;
        #1 chk_eq("lu_rm_unused", 32'(ctl), 32'(C_DEF));
        hz.id_rm_used = 1'b1;
        #1 chk_eq("lu_rm", 32'(ctl), 32'(C_LU));
        hz.branch_taken = 1'b1;
        #1 chk_eq("br_over_lu", 32'(ctl), 32'(C_BR));
        tick();

        // memory wait with pending branch and load-use
        idle();
        hz.mem_req = 1'b1; hz.branch_taken = 1'b1;
        hz.ex_load = 1'b1; hz.ex_rd = 4'd3; hz.id_rn = 4'd3; hz.id_rn_used = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk_eq($sformatf("wait_%0d", i), 32'(ctl), 32'(C_WAIT));
            tick();
        end
        hz.mem_ready = 1'b1;
        #1 chk_eq("wait_ready_br", 32'(ctl), 32'(C_BR));
        tick();
        idle();
        #1 chk_eq("wait_done", 32'(ctl), 32'(C_DEF));
        chk_eq("wait_no_err", 32'(hz.mem_timeout_err), 32'd0);
        tick();

        // halt: RUN cycle, 4 drain cycles (one with a branch), then halted
        hz.halt_req = 1'b1;
        #1 chk_eq("halt_run_cycle", 32'(ctl), 32'(C_DEF));
        tick();
        for (int i = 0; i < 4; i++) begin
            hz.branch_taken = (i == 1);
            #1 chk_eq($sformatf("drain_%0d", i), 32'(ctl), (i == 1) ? 32'(C_BR) : 32'(C_DRAIN));
            tick();
        end
        hz.branch_taken = 1'b0;
        #1 chk_eq("halted", 32'(ctl), 32'(C_HALT));
        tick();
        hz.halt_req = 1'b0;
        #1 chk_eq("halted_release", 32'(ctl), 32'(C_HALT));
        tick();
        #1 chk_eq("halt_resume", 32'(ctl), 32'(C_DEF));
        tick();

        // halt with a 2-cycle memory wait mid-drain
        hz.halt_req = 1'b1;
        #1 chk_eq("hw_run_cycle", 32'(ctl), 32'(C_DEF));
        tick();
        #1 chk_eq("hw_drain_0", 32'(ctl), 32'(C_DRAIN));
        tick();
        #1 chk_eq("hw_drain_1", 32'(ctl), 32'(C_DRAIN));
        tick();
        hz.mem_req = 1'b1;
        #1 chk_eq("hw_wait_0", 32'(ctl), 32'(C_DRWAIT));
        tick();
        #1 chk_eq("hw_wait_1", 32'(ctl), 32'(C_DRWAIT));
        tick();
        hz.mem_ready = 1'b1;
        #1 chk_eq("hw_ready", 32'(ctl), 32'(C_DRAIN));
        tick();
        hz.mem_req = 1'b0; hz.mem_ready = 1'b0;
        #1 chk_eq("hw_drain_3", 32'(ctl), 32'(C_DRAIN));
        tick();
        #1 chk_eq("hw_halted", 32'(ctl), 32'(C_HALT));
        hz.halt_req = 1'b0;
        tick();
        #1 chk_eq("hw_resume", 32'(ctl), 32'(C_DEF));
        tick();

        // halt request withdrawn mid-drain
        hz.halt_req = 1'b1;
        tick();
        hz.halt_req = 1'b0;
        #1 chk_eq("abort_drain", 32'(ctl), 32'(C_DRAIN));
        tick();
        #1 chk_eq("abort_run", 32'(ctl), 32'(C_DEF));
        tick();

        // timeout after 16 wait cycles, sticky afterwards
        hz.mem_req = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            #1;
            if (i == 16) chk_eq("tmo_pre", 32'(hz.mem_timeout_err), 32'd0);
            tick();
        end
        hz.mem_ready = 1'b1;
        #1 chk_eq("tmo_set", 32'(hz.mem_timeout_err), 32'd1);
        chk_eq("tmo_ready_ctl", 32'(ctl), 32'(C_DEF));
        tick();
        idle();
        #1 chk_eq("tmo_sticky", 32'(hz.mem_timeout_err), 32'd1);
        tick();

`ifdef HAZARD_PERF_COUNTERS_EN
        begin
            logic [15:0] s0;
            s0 = hz.stall_cycles;
            hz.ex_load = 1'b1; hz.ex_rd = 4'd5; hz.id_rn = 4'd5; hz.id_rn_used = 1'b1;
            tick();
            idle();
            #1 chk_eq("perf_stall", 32'(hz.stall_cycles), 32'(s0) + 32'd1);
        end
`endif

        // async reset in the middle of a memory wait
        hz.mem_req = 1'b1;
        tick();
        tick();
        #2 reset = 1'b0;
        #1 chk_eq("areset_ctl", 32'(ctl), 32'(C_RST));
        chk_eq("areset_err", 32'(hz.mem_timeout_err), 32'd0);
`ifdef HAZARD_PERF_COUNTERS_EN
        chk_eq("areset_perf", 32'(hz.wait_cycles), 32'd0);
`endif
        #1 reset = 1'b1;
        idle();
        hz.halt_req = 1'b1;
        #1 chk_eq("post_rst_def", 32'(ctl), 32'(C_DEF));
        tick();
        #1 chk_eq("post_rst_drain", 32'(ctl), 32'(C_DRAIN));
        hz.halt_req = 1'b0;
        tick();
        hz.mem_req = 1'b1; hz.mem_ready = 1'b1;
        #1 chk_eq("req_ready_nowait", 32'(ctl), 32'(C_DEF));
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
